// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the programmable clock divider.
package clk_div_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int MIN_DIV  = 2;
  localparam int RST_DIV  = 10;
  localparam int RST_HIGH = 5;
endpackage

// File: rtl/clk_div_prog_if.sv
// Control, configuration and status bundle of clk_div_prog.
interface clk_div_prog_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             clr;
  logic             oneshot;
  logic             down;
  logic             start;
  logic             cfg_we;
  logic [WIDTH-1:0] cfg_div;
  logic [WIDTH-1:0] cfg_high;
  logic [WIDTH-1:0] count;
  logic             clk_div;
  logic             tc;
  logic             busy;
  logic             cfg_err;

  modport master (
    output en, clr, oneshot, down, start, cfg_we, cfg_div, cfg_high,
    input  count, clk_div, tc, busy, cfg_err
  );

  modport slave (
    input  en, clr, oneshot, down, start, cfg_we, cfg_div, cfg_high,
    output count, clk_div, tc, busy, cfg_err
  );
endinterface

// File: rtl/clk_div_cfg.sv
// Ratio/high-time registers: validates writes, shadows them while running
// and commits them only on a period boundary.
module clk_div_cfg
  import clk_div_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEF_DIV  = RST_DIV,
  parameter int DEF_HIGH = RST_HIGH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  input  logic             idle,
  input  logic             wrap,
  output logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] high,
  output logic             cfg_err
);
  logic [WIDTH-1:0] div_q, div_d, high_q, high_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d, pend_high_q, pend_high_d;
  logic             pend_q, pend_d, cfg_err_q, cfg_err_d;
  logic             wr_ok;

  assign wr_ok = cfg_we && (cfg_div >= WIDTH'(MIN_DIV)) && (cfg_high <= cfg_div);

  always_comb begin
    div_d       = div_q;
    high_d      = high_q;
    pend_div_d  = pend_div_q;
    pend_high_d = pend_high_q;
    pend_d      = pend_q;
    cfg_err_d   = cfg_err_q | (cfg_we & ~wr_ok);
    // A fresh write at the boundary is newer than any shadowed value.
    if (idle || wrap) begin
      if (wr_ok) begin
        div_d  = cfg_div;
        high_d = cfg_high;
      end else if (pend_q) begin
        div_d  = pend_div_q;
        high_d = pend_high_q;
      end
      pend_d = 1'b0;
    end else if (wr_ok) begin
      pend_d      = 1'b1;
      pend_div_d  = cfg_div;
      pend_high_d = cfg_high;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q       <= WIDTH'(DEF_DIV);
      high_q      <= WIDTH'(DEF_HIGH);
      pend_div_q  <= '0;
      pend_high_q <= '0;
      pend_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      div_q       <= div_d;
      high_q      <= high_d;
      pend_div_q  <= pend_div_d;
      pend_high_q <= pend_high_d;
      pend_q      <= pend_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign div     = div_q;
  assign high    = high_q;
  assign cfg_err = cfg_err_q;
endmodule

// File: rtl/clk_div_prog.sv
// Run-time programmable divider: IDLE/RUN FSM, phase counter and
// registered divided waveform / terminal-count outputs.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEF_DIV  = RST_DIV,
  parameter int DEF_HIGH = RST_HIGH
) (
  input  logic         clk,
  input  logic         rst,
  clk_div_prog_if.slave bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic             clk_div_q, clk_div_d, tc_q, tc_d;
  logic [WIDTH-1:0] div, high, last;
  logic             wrap;

  clk_div_cfg #(
    .WIDTH    (WIDTH),
    .DEF_DIV  (DEF_DIV),
    .DEF_HIGH (DEF_HIGH)
  ) u_cfg (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (bus.cfg_we),
    .cfg_div  (bus.cfg_div),
    .cfg_high (bus.cfg_high),
    .idle     (state_q == IDLE),
    .wrap     (wrap),
    .div      (div),
    .high     (high),
    .cfg_err  (bus.cfg_err)
  );

  assign last = div - WIDTH'(1);
  // The boundary is seen even under clr so a shadowed config still commits.
  assign wrap = (state_q == RUN) && bus.en && (phase_q == last);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    clk_div_d = clk_div_q;
    tc_d      = 1'b0;
    if (state_q == IDLE) begin
      clk_div_d = 1'b0;
    end else if (bus.en) begin
      clk_div_d = (phase_q < high);
    end
    if (bus.clr) begin
      phase_d = '0;
      if (bus.oneshot) state_d = IDLE;
    end else if (state_q == IDLE) begin
      phase_d = '0;
      if (bus.en && (!bus.oneshot || bus.start)) state_d = RUN;
    end else if (bus.en) begin
      if (phase_q == last) begin
        phase_d = '0;
        tc_d    = 1'b1;
        if (bus.oneshot) state_d = IDLE;
      end else begin
        phase_d = phase_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      clk_div_q <= 1'b0;
      tc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      clk_div_q <= clk_div_d;
      tc_q      <= tc_d;
    end
  end

  assign bus.count   = bus.down ? (last - phase_q) : phase_q;
  assign bus.clk_div = clk_div_q;
  assign bus.tc      = tc_q;
  assign bus.busy    = (state_q == RUN);
endmodule
